vgafb_csr_mlayer: RTL and testbench

VGAFB_CSR_MLAYER -- requirements
Module: vgafb_csr_mlayer

---
 rtl/vgafb_pkg.sv | 43 ++++
 rtl/vgafb_csr_mlayer_if.sv | 10 +
 rtl/vgafb_csr_layer.sv | 57 +++++
 rtl/vgafb_csr_mlayer.sv | 177 +++++++++++++++++
 tb/tb_vgafb_csr_mlayer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vgafb_pkg.sv
// Shared constants for the multi-layer VGA framebuffer CSR bank: register map,
// layer window geometry and power-on video timing (640x480).
package vgafb_pkg;

  typedef logic [10:0] timing_t;

  localparam int unsigned NTIMING = 8;

  localparam logic [5:0] REG_CTRL      = 6'd0;
  localparam logic [5:0] REG_HRES      = 6'd1;
  localparam logic [5:0] REG_VSCAN     = 6'd8;
  localparam logic [5:0] REG_STATUS    = 6'd9;
  localparam logic [5:0] REG_IRQ_EN    = 6'd10;
  localparam logic [5:0] REG_FRAME_CNT = 6'd11;
  localparam logic [5:0] REG_DDC       = 6'd12;
  localparam logic [5:0] REG_CLKSEL    = 6'd13;

  localparam int unsigned LAYER_BASE   = 16;
  localparam int unsigned LAYER_STRIDE = 4;

  localparam logic [1:0] LREG_BASE     = 2'd0;
  localparam logic [1:0] LREG_BASE_ACT = 2'd1;
  localparam logic [1:0] LREG_NBURSTS  = 2'd2;
  localparam logic [1:0] LREG_EN       = 2'd3;

  localparam logic [17:0] NBURSTS_RST = 18'd19200;

  // Order matches registers 1..8: hres, hsync_start, hsync_end, hscan,
  // vres, vsync_start, vsync_end, vscan.
  function automatic timing_t timing_rst(input int unsigned i);
    case (i)
      0:       return 11'd640;
      1:       return 11'd656;
      2:       return 11'd752;
      3:       return 11'd799;
      4:       return 11'd480;
      5:       return 11'd491;
      6:       return 11'd493;
      default: return 11'd523;
    endcase
  endfunction

endpackage

// File: rtl/vgafb_csr_mlayer_if.sv
// CSR bus between the system bus bridge (master) and the framebuffer CSR bank (slave).
interface vgafb_csr_mlayer_if;
  logic [14:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, csr_we, csr_di, input csr_do);
  modport slave  (input csr_a, csr_we, csr_di, output csr_do);
endinterface

// File: rtl/vgafb_csr_layer.sv
// One framebuffer layer's register window: base address, DMA-acknowledged
// base address, burst count and enable.
module vgafb_csr_layer
  import vgafb_pkg::*;
#(
  parameter int unsigned fml_depth = 26,
  parameter logic        en_rst    = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 we,
  input  logic [1:0]           reg_sel,
  input  logic [31:0]          di,
  input  logic                 ack,
  output logic [fml_depth-1:0] baseaddress,
  output logic [17:0]          nbursts,
  output logic                 layer_en,
  output logic [31:0]          rd
);

  logic [fml_depth-1:0] base_act;
  logic                 unused_di;

  assign unused_di = ^di;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baseaddress <= '0;
      base_act    <= '0;
      nbursts     <= NBURSTS_RST;
      layer_en    <= en_rst;
    end else begin
      if (we) begin
        case (reg_sel)
          LREG_BASE:    baseaddress <= di[fml_depth-1:0];
          LREG_NBURSTS: nbursts     <= di[17:0];
          LREG_EN:      layer_en    <= di[0];
          default:      ;
        endcase
      end
      // DMA has taken the current base; record what it is now scanning.
      if (ack) base_act <= baseaddress;
    end
  end

  always_comb begin
    rd = '0;
    case (reg_sel)
      LREG_BASE:     rd = 32'(baseaddress);
      LREG_BASE_ACT: rd = 32'(base_act);
      LREG_NBURSTS:  rd = 32'(nbursts);
      LREG_EN:       rd = {31'b0, layer_en};
      default:       rd = '0;
    endcase
  end

endmodule

// File: rtl/vgafb_csr_mlayer.sv
// Multi-layer VGA framebuffer CSR bank with frame-synchronous timing commit.
// Optional DDC (I2C) pins are built only when VGAFB_CSR_DDC_EN is defined.
module vgafb_csr_mlayer
  import vgafb_pkg::*;
#(
  parameter logic [4:0]  csr_addr  = 5'h0,
  parameter int unsigned fml_depth = 26,
  parameter int unsigned nlayers   = 2
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  vgafb_csr_mlayer_if.slave            csr,
  input  logic                         frame_start,
  input  logic [nlayers-1:0]           baseaddress_ack,
  output logic                         vga_rst,
  output logic [10:0]                  hres,
  output logic [10:0]                  hsync_start,
  output logic [10:0]                  hsync_end,
  output logic [10:0]                  hscan,
  output logic [10:0]                  vres,
  output logic [10:0]                  vsync_start,
  output logic [10:0]                  vsync_end,
  output logic [10:0]                  vscan,
  output logic [nlayers*fml_depth-1:0] baseaddress,
  output logic [nlayers*18-1:0]        nbursts,
  output logic [nlayers-1:0]           layer_en,
  output logic                         irq,
  inout  wire                          vga_sda,
  output logic                         vga_sdc,
  output logic [1:0]                   clksel
);

  logic        sel;
  logic [5:0]  idx;
  logic        wr;
  logic        commit_wr;
  logic        pending;
  logic        status_frame;
  logic        irq_en;
  logic [15:0] frame_cnt;
  logic [31:0] ddc_rd;
  logic [31:0] rd_data;
  logic        unused_csr_a;
  timing_t     shadow [NTIMING];
  timing_t     active [NTIMING];
  logic [31:0] layer_rd [nlayers];

  assign sel          = (csr.csr_a[14:10] == csr_addr);
  assign idx          = csr.csr_a[5:0];
  assign wr           = sel & csr.csr_we;
  assign commit_wr    = wr && (idx == REG_CTRL) && csr.csr_di[1];
  assign unused_csr_a = ^csr.csr_a[9:6];

  assign hres        = active[0];
  assign hsync_start = active[1];
  assign hsync_end   = active[2];
  assign hscan       = active[3];
  assign vres        = active[4];
  assign vsync_start = active[5];
  assign vsync_end   = active[6];
  assign vscan       = active[7];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vga_rst      <= 1'b1;
      status_frame <= 1'b0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
      frame_cnt    <= '0;
      clksel       <= '0;
      for (int unsigned i = 0; i < NTIMING; i++) shadow[i] <= timing_rst(i);
    end else begin
      if (wr && idx == REG_CTRL)   vga_rst <= csr.csr_di[0];
      if (wr && idx == REG_IRQ_EN) irq_en  <= csr.csr_di[0];
      if (wr && idx == REG_CLKSEL) clksel  <= csr.csr_di[1:0];
      for (int unsigned i = 0; i < NTIMING; i++)
        if (wr && idx == 6'(32'(REG_HRES) + i)) shadow[i] <= csr.csr_di[10:0];
      if (frame_start)
        status_frame <= 1'b1;
      else if (wr && idx == REG_STATUS && csr.csr_di[0])
        status_frame <= 1'b0;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      irq <= status_frame & irq_en;
    end
  end

  // A commit arriving on a frame_start cycle is not consumed by that frame:
  // pending is reloaded with it so the next frame_start applies it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= 1'b0;
      for (int unsigned i = 0; i < NTIMING; i++) active[i] <= timing_rst(i);
    end else if (vga_rst) begin
      pending <= 1'b0;
      active  <= shadow;
    end else if (frame_start && pending) begin
      pending <= commit_wr;
      active  <= shadow;
    end else if (commit_wr) begin
      pending <= 1'b1;
    end
  end

`ifdef VGAFB_CSR_DDC_EN
  logic       sda_o;
  logic       sda_oe;
  logic [1:0] sda_sync;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sda_o    <= 1'b0;
      sda_oe   <= 1'b0;
      vga_sdc  <= 1'b0;
      sda_sync <= '0;
    end else begin
      sda_sync <= {sda_sync[0], vga_sda};
      if (wr && idx == REG_DDC) begin
        sda_o   <= csr.csr_di[1];
        sda_oe  <= csr.csr_di[2];
        vga_sdc <= csr.csr_di[3];
      end
    end
  end

  // Open-drain: only ever pull low, release otherwise.
  assign vga_sda = (sda_oe & ~sda_o) ? 1'b0 : 1'bz;
  assign ddc_rd  = {28'b0, vga_sdc, sda_oe, sda_o, sda_sync[1]};
`else
  assign vga_sda = 1'bz;
  assign vga_sdc = 1'b0;
  assign ddc_rd  = '0;
`endif

  for (genvar l = 0; l < nlayers; l++) begin : g_layer
    logic lsel;
    assign lsel = sel && (idx[5:2] == 4'((LAYER_BASE / LAYER_STRIDE) + l));

    vgafb_csr_layer #(
      .fml_depth (fml_depth),
      .en_rst    ((l == 0) ? 1'b1 : 1'b0)
    ) u_layer (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .we          (lsel & csr.csr_we),
      .reg_sel     (idx[1:0]),
      .di          (csr.csr_di),
      .ack         (baseaddress_ack[l]),
      .baseaddress (baseaddress[l*fml_depth +: fml_depth]),
      .nbursts     (nbursts[l*18 +: 18]),
      .layer_en    (layer_en[l]),
      .rd          (layer_rd[l])
    );
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_CTRL:      rd_data = {30'b0, pending, vga_rst};
      REG_STATUS:    rd_data = {30'b0, pending, status_frame};
      REG_IRQ_EN:    rd_data = {31'b0, irq_en};
      REG_FRAME_CNT: rd_data = {16'b0, frame_cnt};
      REG_DDC:       rd_data = ddc_rd;
      REG_CLKSEL:    rd_data = {30'b0, clksel};
      default:       rd_data = '0;
    endcase
    for (int unsigned i = 0; i < NTIMING; i++)
      if (idx == 6'(32'(REG_HRES) + i)) rd_data = 32'(shadow[i]);
    for (int unsigned l = 0; l < nlayers; l++)
      if (idx[5:2] == 4'((LAYER_BASE / LAYER_STRIDE) + l)) rd_data = layer_rd[l];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) csr.csr_do <= '0;
    else            csr.csr_do <= sel ? rd_data : '0;
  end

endmodule

// File: tb/tb_vgafb_csr_mlayer.sv
// Self-checking bench for vgafb_csr_mlayer (default build, DDC disabled):
// directed scenarios plus randomized CSR traffic against a behavioural model.
module tb_vgafb_csr_mlayer;

  localparam int unsigned NL = 2;
  localparam int unsigned FD = 26;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic                 frame_start;
  logic [NL-1:0]        baseaddress_ack;
  logic                 vga_rst;
  logic [10:0]          hres, hsync_start, hsync_end, hscan;
  logic [10:0]          vres, vsync_start, vsync_end, vscan;
  logic [NL*FD-1:0]     baseaddress;
  logic [NL*18-1:0]     nbursts;
  logic [NL-1:0]        layer_en;
  logic                 irq;
  wire                  vga_sda;
  logic                 vga_sdc;
  logic [1:0]           clksel;

  vgafb_csr_mlayer_if csr ();

  always #5 sys_clk = ~sys_clk;

  vgafb_csr_mlayer #(
    .csr_addr  (5'h0),
    .fml_depth (FD),
    .nlayers   (NL)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .csr             (csr),
    .frame_start     (frame_start),
    .baseaddress_ack (baseaddress_ack),
    .vga_rst         (vga_rst),
    .hres            (hres),
    .hsync_start     (hsync_start),
    .hsync_end       (hsync_end),
    .hscan           (hscan),
    .vres            (vres),
    .vsync_start     (vsync_start),
    .vsync_end       (vsync_end),
    .vscan           (vscan),
    .baseaddress     (baseaddress),
    .nbursts         (nbursts),
    .layer_en        (layer_en),
    .irq             (irq),
    .vga_sda         (vga_sda),
    .vga_sdc         (vga_sdc),
    .clksel          (clksel)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the register bank.
  int unsigned m_shadow [8];
  int unsigned m_active [8];
  int unsigned m_base [NL];
  int unsigned m_act  [NL];
  int unsigned m_nb   [NL];
  bit          m_en   [NL];
  bit          m_pending, m_vga_rst, m_frame, m_irq_en, m_irq;
  int unsigned m_cnt, m_clksel;
  int unsigned TRST [8] = '{640, 656, 752, 799, 480, 491, 493, 523};

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = TRST[i];
      m_active[i] = TRST[i];
    end
    for (int l = 0; l < NL; l++) begin
      m_base[l] = 0;
      m_act[l]  = 0;
      m_nb[l]   = 19200;
      m_en[l]   = (l == 0);
    end
    m_pending = 0; m_vga_rst = 1; m_frame = 0; m_irq_en = 0; m_irq = 0;
    m_cnt = 0; m_clksel = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [14:0] a);
    int unsigned i;
    if (a[14:10] != 5'd0) return 32'd0;
    i = int'(a[5:0]);
    if (i == 0) return {30'd0, m_pending, m_vga_rst};
    if (i >= 1 && i <= 8) return m_shadow[i-1];
    if (i == 9) return {30'd0, m_pending, m_frame};
    if (i == 10) return {31'd0, m_irq_en};
    if (i == 11) return m_cnt;
    if (i == 13) return m_clksel;
    if (i >= 16 && i < 16 + 4*NL) begin
      case ((i - 16) % 4)
        0: return m_base[(i-16)/4];
        1: return m_act[(i-16)/4];
        2: return m_nb[(i-16)/4];
        default: return {31'd0, m_en[(i-16)/4]};
      endcase
    end
    return 32'd0;
  endfunction

  function automatic void model_step(input logic we, input logic [14:0] a,
                                     input logic [31:0] di, input logic fs,
                                     input logic [NL-1:0] ack);
    int unsigned old_shadow [8];
    int unsigned old_base [NL];
    bit old_pending, old_vga_rst, old_frame, commit, w1c, hit;
    int unsigned i;
    old_shadow  = m_shadow;
    old_base    = m_base;
    old_pending = m_pending;
    old_vga_rst = m_vga_rst;
    old_frame   = m_frame;
    hit    = we && (a[14:10] == 5'd0);
    i      = int'(a[5:0]);
    commit = hit && i == 0 && di[1];
    w1c    = hit && i == 9 && di[0];
    m_irq  = old_frame & m_irq_en;
    if (hit) begin
      if (i == 0) m_vga_rst = di[0];
      if (i >= 1 && i <= 8) m_shadow[i-1] = di & 32'h7FF;
      if (i == 10) m_irq_en = di[0];
      if (i == 13) m_clksel = di & 32'h3;
      if (i >= 16 && i < 16 + 4*NL) begin
        case ((i - 16) % 4)
          0: m_base[(i-16)/4] = di & ((32'd1 << FD) - 1);
          2: m_nb[(i-16)/4]   = di & 32'h3FFFF;
          3: m_en[(i-16)/4]   = di[0];
          default: ;
        endcase
      end
    end
    if (old_vga_rst) begin
      m_active  = old_shadow;
      m_pending = 0;
    end else if (fs && old_pending) begin
      m_active  = old_shadow;
      m_pending = commit;
    end else if (commit) begin
      m_pending = 1;
    end
    if (fs) m_frame = 1;
    else if (w1c) m_frame = 0;
    if (fs) m_cnt = (m_cnt + 1) % 65536;
    for (int l = 0; l < NL; l++) if (ack[l]) m_act[l] = old_base[l];
  endfunction

  function automatic logic [10:0] timing_out(input int i);
    case (i)
      0: return hres;        1: return hsync_start;
      2: return hsync_end;   3: return hscan;
      4: return vres;        5: return vsync_start;
      6: return vsync_end;   default: return vscan;
    endcase
  endfunction

  task automatic check_outputs();
    chk("vga_rst", {31'd0, vga_rst}, {31'd0, m_vga_rst});
    for (int i = 0; i < 8; i++) chk($sformatf("timing%0d", i), 32'(timing_out(i)), m_active[i]);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("base%0d", l), 32'(baseaddress[l*FD +: FD]), m_base[l]);
      chk($sformatf("nbursts%0d", l), 32'(nbursts[l*18 +: 18]), m_nb[l]);
      chk($sformatf("layer_en%0d", l), {31'd0, layer_en[l]}, {31'd0, m_en[l]});
    end
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("clksel", {30'd0, clksel}, m_clksel);
    chk("vga_sdc", {31'd0, vga_sdc}, 32'd0);
  endtask

  logic [31:0] last_do;

  task automatic tick(input logic we, input logic [14:0] a, input logic [31:0] di,
                      input logic fs, input logic [NL-1:0] ack);
    logic [31:0] exp_rd;
    csr.csr_we = we; csr.csr_a = a; csr.csr_di = di;
    frame_start = fs; baseaddress_ack = ack;
    exp_rd = model_read(a);
    model_step(we, a, di, fs, ack);
    @(posedge sys_clk); #1;
    csr.csr_we = 1'b0; frame_start = 1'b0; baseaddress_ack = '0;
    last_do = csr.csr_do;
    chk("csr_do", csr.csr_do, exp_rd);
    check_outputs();
  endtask

  task automatic wr(input int unsigned idx, input logic [31:0] val);
    tick(1'b1, 15'(idx), val, 1'b0, '0);
  endtask

  task automatic rd(input int unsigned idx);
    tick(1'b0, 15'(idx), 32'd0, 1'b0, '0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_csr_do", csr.csr_do, 32'd0);
    check_outputs();
    @(posedge sys_clk); #1;
    check_outputs();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [14:0] a;
    logic [31:0] d;
    logic        we, fs;
    logic [NL-1:0] ack;

    csr.csr_a = '0; csr.csr_we = 1'b0; csr.csr_di = '0;
    frame_start = 1'b0; baseaddress_ack = '0; sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    do_reset();

    // Power-on register values.
    for (int unsigned i = 1; i <= 8; i++) begin
      rd(i);
      chk($sformatf("rst_reg%0d", i), last_do, TRST[i-1]);
    end
    rd(0);  chk("rst_ctrl", last_do, 32'd1);

    // Commit applied only at frame_start.
    wr(0, 32'd0);
    wr(1, 32'd800);
    wr(0, 32'd2);
    chk("hres_before_frame", 32'(hres), 32'd640);
    rd(9);  chk("status_pending", last_do & 32'h2, 32'h2);
    tick(1'b0, 15'd0, 32'd0, 1'b1, '0);
    chk("hres_after_frame", 32'(hres), 32'd800);
    rd(0);  chk("pending_cleared", last_do, 32'd0);

    // Commit coincident with frame_start waits for the next frame.
    wr(1, 32'd900);
    tick(1'b1, 15'd0, 32'd2, 1'b1, '0);
    chk("hres_same_cycle", 32'(hres), 32'd800);
    tick(1'b0, 15'd0, 32'd0, 1'b1, '0);
    chk("hres_next_frame", 32'(hres), 32'd900);

    // Interrupt and W1C priority.
    wr(10, 32'd1);
    wr(9, 32'd1); rd(9); rd(9);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    tick(1'b0, 15'd9, 32'd0, 1'b1, '0); rd(9);
    chk("irq_set", {31'd0, irq}, 32'd1);
    tick(1'b1, 15'd9, 32'd1, 1'b1, '0); rd(9); rd(9);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    wr(9, 32'd1); rd(9);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // Layer 1 base address handoff.
    wr(20, 32'h123400);
    tick(1'b0, 15'd0, 32'd0, 1'b0, 2'b10);
    rd(21); chk("layer1_act", last_do, 32'h123400);
    rd(17); chk("layer0_act", last_do, 32'd0);

    // DDC register inert in the default build.
    wr(12, 32'hF);
    rd(12); chk("ddc_read", last_do, 32'd0);
    chk("sda_hiz", {31'd0, (vga_sda === 1'bz)}, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      a = {($urandom_range(0, 9) == 0) ? 5'd1 : 5'd0, 4'($urandom), 6'($urandom_range(0, 31))};
      we = 1'($urandom);
      d  = $urandom;
      if (a[5:0] == 6'd0) d[0] = ($urandom_range(0, 7) == 0);
      fs  = ($urandom_range(0, 3) == 0);
      ack = NL'($urandom);
      tick(we, a, d, fs, ack);
    end

    // Frame counter wrap from a fresh reset.
    @(posedge sys_clk); #1;
    do_reset();
    for (int n = 0; n < 65536; n++) tick(1'b0, 15'd11, 32'd0, 1'b1, '0);
    rd(11); chk("frame_cnt_wrap", last_do, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
